// File: rtl/dma_splitter_pkg.sv
// Shared definitions for the DMA read-request splitter: default geometry,
// FSM state encoding and read-request payload layout.
package dma_splitter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH      = 64;
  localparam int unsigned DEF_SIZE_WIDTH      = 15;
  localparam int unsigned DEF_ATOM_BYTES      = 32;
  localparam int unsigned DEF_BURST_ATOMS     = 8;
  localparam int unsigned DEF_MAX_OUTSTANDING = 64;
  localparam int unsigned CMD_ATOMS_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } spl_state_e;

  // Payload is {size, addr} with size (atoms-1) in the MSBs.
  function automatic int unsigned pd_width(input int unsigned aw, input int unsigned sw);
    return aw + sw;
  endfunction

  function automatic int unsigned pd_size_lsb(input int unsigned aw);
    return aw;
  endfunction

  typedef struct packed {
    logic [DEF_SIZE_WIDTH-1:0] size;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } rd_req_pd_t;

endpackage

// File: rtl/dma_credit_cnt.sv
// Outstanding-atom credit counter: adds a burst per issued request, removes one
// per returned beat, and latches a sticky flag on a beat with nothing owed.
module dma_credit_cnt #(
  parameter int unsigned CNT_W = 7,
  parameter int unsigned INC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en_i,
  input  logic [INC_W-1:0] inc_amt_i,
  input  logic             dec_en_i,
  output logic [CNT_W-1:0] count_nxt_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             underflow_q;
  logic             underflow_d;

  // A beat seen with a zero count is dropped rather than wrapping the counter.
  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q;
    if (inc_en_i) begin
      count_d = count_q + CNT_W'(inc_amt_i);
    end else begin
      count_d = count_q;
    end
    if (dec_en_i) begin
      if (count_q == {CNT_W{1'b0}}) begin
        underflow_d = 1'b1;
      end else begin
        count_d = count_d - CNT_W'(1);
      end
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= {CNT_W{1'b0}};
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_nxt_o = count_d;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/dma_rd_req_splitter.sv
// Splits a DMA read command into boundary-aligned bursts, issuing them under an
// outstanding-atom credit limit and signalling done once all beats return.
module dma_rd_req_splitter
  import dma_splitter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned SIZE_WIDTH      = DEF_SIZE_WIDTH,
  parameter int unsigned ATOM_BYTES      = DEF_ATOM_BYTES,
  parameter int unsigned BURST_ATOMS     = DEF_BURST_ATOMS,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        cmd_valid,
  output logic                                        cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                       cmd_addr,
  input  logic [CMD_ATOMS_WIDTH-1:0]                  cmd_atoms,
  output logic                                        rd_req_valid,
  input  logic                                        rd_req_ready,
  output logic [pd_width(ADDR_WIDTH, SIZE_WIDTH)-1:0] rd_req_pd,
  input  logic                                        rd_rsp_valid,
  input  logic                                        rd_rsp_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err_underflow
);

  localparam int unsigned ATOM_LSB = $clog2(ATOM_BYTES);
  localparam int unsigned IDX_W    = $clog2(BURST_ATOMS);
  localparam int unsigned BURST_W  = $clog2(BURST_ATOMS + 1);
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam int unsigned PD_W     = pd_width(ADDR_WIDTH, SIZE_WIDTH);

  spl_state_e state_q;
  spl_state_e state_d;

  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ADDR_WIDTH-1:0]      addr_d;
  logic [CMD_ATOMS_WIDTH-1:0] rem_q;
  logic [CMD_ATOMS_WIDTH-1:0] rem_d;
  logic                       req_valid_q;
  logic                       req_valid_d;
  logic [PD_W-1:0]            req_pd_q;
  logic [PD_W-1:0]            req_pd_d;
  logic                       cmd_ready_q;
  logic                       cmd_ready_d;
  logic                       busy_q;
  logic                       busy_d;
  logic                       done_q;
  logic                       done_d;

  logic                       cmd_hs_s;
  logic                       req_hs_s;
  logic                       rsp_beat_s;
  logic [BURST_W-1:0]         cur_burst_s;
  logic [BURST_W-1:0]         nxt_burst_s;
  logic [CNT_W-1:0]           cnt_nxt_s;
  logic                       underflow_s;
  logic                       credit_ok_s;

  // Burst is capped by the atoms left before the next BURST_ATOMS boundary.
  function automatic logic [BURST_W-1:0] burst_of(input logic [IDX_W-1:0]           idx,
                                                  input logic [CMD_ATOMS_WIDTH-1:0] rem);
    logic [CMD_ATOMS_WIDTH-1:0] room;
    room = CMD_ATOMS_WIDTH'(BURST_ATOMS) - CMD_ATOMS_WIDTH'(idx);
    return (rem < room) ? BURST_W'(rem) : BURST_W'(room);
  endfunction

  assign cmd_hs_s    = cmd_valid && cmd_ready_q;
  assign req_hs_s    = req_valid_q && rd_req_ready;
  assign rsp_beat_s  = rd_rsp_valid && rd_rsp_ready;
  assign cur_burst_s = burst_of(addr_q[ATOM_LSB +: IDX_W], rem_q);
  assign nxt_burst_s = burst_of(addr_d[ATOM_LSB +: IDX_W], rem_d);

  dma_credit_cnt #(
    .CNT_W (CNT_W),
    .INC_W (BURST_W)
  ) u_credit (
    .clk         (clk),
    .reset       (reset),
    .inc_en_i    (req_hs_s),
    .inc_amt_i   (cur_burst_s),
    .dec_en_i    (rsp_beat_s),
    .count_nxt_o (cnt_nxt_s),
    .underflow_o (underflow_s)
  );

  // Credit uses the post-edge count so a returning beat frees space immediately.
  assign credit_ok_s = (SUM_W'(cnt_nxt_s) + SUM_W'(nxt_burst_s)) <= SUM_W'(MAX_OUTSTANDING);

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (state_q == ST_IDLE) begin
      if (cmd_hs_s) begin
        addr_d = cmd_addr & ~(ADDR_WIDTH'(ATOM_BYTES) - ADDR_WIDTH'(1));
        rem_d  = cmd_atoms;
      end else begin
        addr_d = addr_q;
        rem_d  = rem_q;
      end
    end else if (req_hs_s) begin
      addr_d = addr_q + (ADDR_WIDTH'(cur_burst_s) << ATOM_LSB);
      rem_d  = rem_q - CMD_ATOMS_WIDTH'(cur_burst_s);
    end else begin
      addr_d = addr_q;
      rem_d  = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs_s && (cmd_atoms != CMD_ATOMS_WIDTH'(0))) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_hs_s && (rem_d == CMD_ATOMS_WIDTH'(0))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (cnt_nxt_s == CNT_W'(0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A presented request is frozen until taken; otherwise the next one is staged.
  always_comb begin
    req_valid_d = 1'b0;
    req_pd_d    = req_pd_q;
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = 1'b0;
    if (state_d == ST_ISSUE) begin
      if (req_valid_q && !rd_req_ready) begin
        req_valid_d = 1'b1;
        req_pd_d    = req_pd_q;
      end else begin
        req_valid_d = credit_ok_s;
        req_pd_d    = {SIZE_WIDTH'(nxt_burst_s - BURST_W'(1)), addr_d};
      end
    end else begin
      req_valid_d = 1'b0;
      req_pd_d    = req_pd_q;
    end
    if ((state_q == ST_IDLE) && cmd_hs_s && (cmd_atoms == CMD_ATOMS_WIDTH'(0))) begin
      done_d = 1'b1;
    end else if ((state_q == ST_DRAIN) && (state_d == ST_IDLE)) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= {ADDR_WIDTH{1'b0}};
      rem_q       <= {CMD_ATOMS_WIDTH{1'b0}};
      req_valid_q <= 1'b0;
      req_pd_q    <= {PD_W{1'b0}};
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      req_valid_q <= req_valid_d;
      req_pd_q    <= req_pd_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rd_req_valid  = req_valid_q;
  assign rd_req_pd     = req_pd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_underflow = underflow_s;

endmodule

// File: tb/tb_dma_rd_req_splitter.sv
// Randomized and directed bench for dma_rd_req_splitter against a queue-based
// reference model that splits commands arithmetically and tracks credit.
module tb_dma_rd_req_splitter;
  import dma_splitter_pkg::*;

  localparam int AB   = 32;
  localparam int BA   = 8;
  localparam int MAXO = 8;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] atoms;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [15:0] cmd_atoms;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [78:0] rd_req_pd;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready;
  logic        busy;
  logic        done;
  logic        err_underflow;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  logic [78:0] hs_log[$];

  req_t m_q[$];
  bit   m_busy, m_valid, m_done, m_err, m_cmd_ready;
  int   m_out;

  always #5 clk = ~clk;

  dma_rd_req_splitter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_atoms     (cmd_atoms),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_pd     (rd_req_pd),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_ready  (rd_rsp_ready),
    .busy          (busy),
    .done          (done),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk_pd(input int atoms, input logic [63:0] addr);
    rd_req_pd_t p;
    p.size = 15'(atoms - 1);
    p.addr = addr;
    return 128'(p);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_valid = 0; m_done = 0; m_err = 0; m_cmd_ready = 1; m_out = 0;
  endtask

  // Reference split: walk the range, never crossing a BURST_ATOMS*AB boundary.
  task automatic model_split(input logic [63:0] a, input int atoms);
    logic [63:0] addr;
    logic [63:0] mask;
    int rem, room, b;
    mask = 64'(AB - 1);
    addr = a & ~mask;
    rem  = atoms;
    while (rem > 0) begin
      room = BA - int'((addr / 64'(AB)) % 64'(BA));
      b    = (rem < room) ? rem : room;
      m_q.push_back('{addr, 16'(b)});
      addr = addr + 64'(b * AB);
      rem  = rem - b;
    end
  endtask

  // Compare outputs for the current cycle, then advance the model by one edge.
  task automatic tick();
    bit hs, rsp, acc;
    int out_n;
    check("cmd_ready", 128'(cmd_ready), 128'(m_cmd_ready));
    check("rd_req_valid", 128'(rd_req_valid), 128'(m_valid));
    check("busy", 128'(busy), 128'(m_busy));
    check("done", 128'(done), 128'(m_done));
    check("err_underflow", 128'(err_underflow), 128'(m_err));
    if (m_valid && m_q.size() > 0)
      check("rd_req_pd", 128'(rd_req_pd), mk_pd(int'(m_q[0].atoms), m_q[0].addr));
    if (rd_req_valid === 1'b1 && rd_req_ready) hs_log.push_back(rd_req_pd);
    if (done === 1'b1) n_done++;
    if (reset) begin
      model_reset();
    end else begin
      hs  = m_valid && rd_req_ready;
      rsp = rd_rsp_valid && rd_rsp_ready;
      acc = m_cmd_ready && cmd_valid;
      out_n = m_out;
      if (hs && m_q.size() > 0) begin
        out_n += int'(m_q[0].atoms);
        void'(m_q.pop_front());
      end
      if (rsp) begin
        if (m_out == 0) m_err = 1;
        else out_n -= 1;
      end
      m_done = 0;
      if (acc) begin
        if (cmd_atoms == 16'd0) m_done = 1;
        else begin
          model_split(cmd_addr, int'(cmd_atoms));
          m_busy = 1;
        end
      end else if (m_busy && m_q.size() == 0 && out_n == 0) begin
        m_busy = 0;
        m_done = 1;
      end
      if (m_valid && !rd_req_ready) m_valid = 1;
      else m_valid = m_busy && m_q.size() > 0 && (out_n + int'(m_q[0].atoms) <= MAXO);
      m_out = out_n;
      m_cmd_ready = !m_busy;
    end
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [63:0] a, input int atoms);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_atoms = 16'(atoms);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Return one beat per cycle while atoms are owed, until the command retires.
  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((m_busy || m_done) && n < bound) begin
      rd_req_ready = 1'b1;
      rd_rsp_valid = (m_out > 0);
      rd_rsp_ready = 1'b1;
      tick();
      n++;
    end
    rd_rsp_valid = 1'b0;
    check("drain_timeout", 128'(busy), 128'(0));
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 64'd0; cmd_atoms = 16'd0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_valid", 128'(rd_req_valid), 128'(0));
    check("rst_pd", 128'(rd_req_pd), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err_underflow), 128'(0));
    reset = 1'b0;
    rd_req_ready = 1'b1;
    tick();

    // Three bursts on aligned 256-byte blocks.
    hs_log.delete(); n_done = 0;
    send_cmd(64'h1000, 20);
    drain(200);
    check("t36_nreq", 128'(hs_log.size()), 128'(3));
    check("t36_pd0", 128'(hs_log[0]), mk_pd(8, 64'h1000));
    check("t36_pd1", 128'(hs_log[1]), mk_pd(8, 64'h1100));
    check("t36_pd2", 128'(hs_log[2]), mk_pd(4, 64'h1200));
    check("t36_done", 128'(n_done), 128'(1));

    hs_log.delete();
    send_cmd(64'h10E0, 4);
    drain(100);
    check("t37_pd0", 128'(hs_log[0]), mk_pd(1, 64'h10E0));
    check("t37_pd1", 128'(hs_log[1]), mk_pd(3, 64'h1100));

    hs_log.delete();
    send_cmd(64'hFFFF_FFFF_FFFF_FFE0, 3);
    drain(100);
    check("wrap_pd0", 128'(hs_log[0]), mk_pd(1, 64'hFFFF_FFFF_FFFF_FFE0));
    check("wrap_pd1", 128'(hs_log[1]), mk_pd(2, 64'h0));

    // Backpressure: request must be held unchanged.
    rd_req_ready = 1'b0;
    send_cmd(64'h3000, 8);
    for (int i = 0; i < 5; i++) begin
      check("t38_valid", 128'(rd_req_valid), 128'(1));
      check("t38_pd", 128'(rd_req_pd), mk_pd(8, 64'h3000));
      tick();
    end
    drain(100);

    // Credit stall: second burst waits for all eight beats.
    hs_log.delete();
    rd_req_ready = 1'b1;
    send_cmd(64'h2000, 16);
    repeat (6) tick();
    check("t39_one_req", 128'(hs_log.size()), 128'(1));
    rd_rsp_valid = 1'b1; rd_rsp_ready = 1'b1;
    tick();
    rd_rsp_valid = 1'b0;
    repeat (3) tick();
    check("t39_stalled", 128'(rd_req_valid), 128'(0));
    check("t39_still_one", 128'(hs_log.size()), 128'(1));
    rd_rsp_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rd_rsp_valid = 1'b0;
    check("t39_freed_valid", 128'(rd_req_valid), 128'(1));
    check("t39_freed_pd", 128'(rd_req_pd), mk_pd(8, 64'h2100));
    drain(100);

    // Beat while idle sets the sticky flag; zero-atom command just pulses done.
    rd_rsp_valid = 1'b1; rd_rsp_ready = 1'b1;
    tick();
    rd_rsp_valid = 1'b0;
    repeat (3) tick();
    check("t40_err", 128'(err_underflow), 128'(1));
    hs_log.delete();
    send_cmd(64'h4000, 0);
    check("t40_done", 128'(done), 128'(1));
    tick();
    check("t40_done_once", 128'(done), 128'(0));
    check("t40_noreq", 128'(hs_log.size()), 128'(0));

    // Reset mid-issue with three atoms outstanding.
    send_cmd(64'h10A0, 11);
    tick();
    tick();
    check("t41_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t41_valid", 128'(rd_req_valid), 128'(0));
    check("t41_busy_clr", 128'(busy), 128'(0));
    check("t41_no_done", 128'(done), 128'(0));
    check("t41_err_clr", 128'(err_underflow), 128'(0));
    tick();
    check("t41_no_done2", 128'(done), 128'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0)
        cmd_addr = 64'hFFFF_FFFF_FFFF_FE00 | 64'($urandom_range(0, 511));
      else
        cmd_addr = {$urandom(), $urandom()};
      cmd_atoms    = 16'($urandom_range(0, 40));
      rd_req_ready = ($urandom_range(0, 3) != 0);
      rd_rsp_valid = (m_out > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 63) == 0);
      rd_rsp_ready = ($urandom_range(0, 4) != 0);
      reset        = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 1'b0; cmd_valid = 1'b0;
    drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
